// File: rtl/wishbone_regfile_subordinate.sv
// Wishbone classic subordinate exposing NUM_REGS 32-bit registers, with byte-lane
// writes, optional wait states, abort on strobe drop, and a hardware update port.
module wishbone_regfile_subordinate #(
  parameter int          NUM_REGS    = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] RESET_VAL   = 32'h0,
  parameter logic [31:0] OOR_DATA    = 32'hBAD0_BAD0
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  input  logic [NUM_REGS-1:0]      hw_we_i,
  input  logic [32*NUM_REGS-1:0]   hw_dat_i,
  output logic [32*NUM_REGS-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o
);

  localparam int          IW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [31:0] SPAN     = 32'(4 * NUM_REGS);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t                     r_state, w_next;
  logic [3:0]                 r_cnt, w_cnt_nxt;
  logic [31:0]                r_adr, r_dat;
  logic [3:0]                 r_sel;
  logic                       r_we;
  logic [NUM_REGS-1:0][31:0]  r_regs, w_regs_nxt, w_hw;
  logic [31:0]                r_dat_o;
  logic [NUM_REGS-1:0]        r_pulse, w_pulse_nxt;

  logic                       w_req, w_latch, w_enter_ack;
  logic [31:0]                w_adr, w_dat, w_off, w_rd;
  logic [3:0]                 w_sel;
  logic                       w_we, w_hit;
  logic [IW-1:0]              w_idx;

  assign w_req = wbs_cyc_i & wbs_stb_i;
  assign w_hw  = hw_dat_i;

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_latch   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_latch = 1'b1;
          if (WAIT_STATES == 0) begin
            w_next = ST_ACK;
          end else begin
            w_next    = ST_WAIT;
            w_cnt_nxt = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!w_req)            w_next = ST_IDLE;
        else if (r_cnt == 4'd0) w_next = ST_ACK;
        else                   w_cnt_nxt = r_cnt - 4'd1;
      end
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_enter_ack = (w_next == ST_ACK) && (r_state != ST_ACK);

  // With zero wait states the commit edge is also the accept edge, so the
  // request fields come straight from the bus instead of the latches.
  assign w_adr = (r_state == ST_IDLE) ? wbs_adr_i : r_adr;
  assign w_dat = (r_state == ST_IDLE) ? wbs_dat_i : r_dat;
  assign w_sel = (r_state == ST_IDLE) ? wbs_sel_i : r_sel;
  assign w_we  = (r_state == ST_IDLE) ? wbs_we_i  : r_we;

  assign w_off = w_adr - BASE_ADDR;
  assign w_hit = (w_adr >= BASE_ADDR) && (w_off < SPAN);
  assign w_idx = w_off[IW+1:2];
  assign w_rd  = w_hit ? r_regs[w_idx] : OOR_DATA;

  // Hardware load first, then the bus overrides only its selected bytes.
  always_comb begin
    w_regs_nxt  = r_regs;
    w_pulse_nxt = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (hw_we_i[k]) w_regs_nxt[k] = w_hw[k];
    end
    if (w_enter_ack && w_we && w_hit) begin
      w_pulse_nxt[w_idx] = 1'b1;
      for (int n = 0; n < 4; n++) begin
        if (w_sel[n]) w_regs_nxt[w_idx][8*n +: 8] = w_dat[8*n +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_regs  <= {NUM_REGS{RESET_VAL}};
      r_dat_o <= '0;
      r_pulse <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_adr <= wbs_adr_i;
        r_dat <= wbs_dat_i;
        r_sel <= wbs_sel_i;
        r_we  <= wbs_we_i;
      end
      r_regs  <= w_regs_nxt;
      r_dat_o <= (w_enter_ack && !w_we) ? w_rd : 32'h0;
      r_pulse <= w_pulse_nxt;
    end
  end

  assign wbs_ack_o  = (r_state == ST_ACK);
  assign wbs_dat_o  = r_dat_o;
  assign regs_o     = r_regs;
  assign wr_pulse_o = r_pulse;

endmodule

// File: tb/tb_wishbone_regfile_subordinate.sv
// Bench for the register-file subordinate: two instances (0 and 3 wait states)
// checked every cycle against a transaction-level register model.
module tb_wishbone_regfile_subordinate;
  localparam logic [31:0] B   = 32'h3000_0000;
  localparam logic [31:0] OOR = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst [2], cyc [2], stb [2], we [2], ack [2];
  logic [3:0]   sel [2];
  logic [31:0]  adr [2], dat [2], dat_o [2];
  logic [7:0]   hw_we [2], pulse [2];
  logic [255:0] hw_dat [2], regs [2];

  wishbone_regfile_subordinate #(.NUM_REGS(8), .WAIT_STATES(0)) u0 (
    .wb_clk_i(clk), .wb_rst_i(rst[0]), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]),
    .wbs_we_i(we[0]), .wbs_sel_i(sel[0]), .wbs_adr_i(adr[0]), .wbs_dat_i(dat[0]),
    .wbs_ack_o(ack[0]), .wbs_dat_o(dat_o[0]), .hw_we_i(hw_we[0]), .hw_dat_i(hw_dat[0]),
    .regs_o(regs[0]), .wr_pulse_o(pulse[0]));

  wishbone_regfile_subordinate #(.NUM_REGS(8), .WAIT_STATES(3)) u3 (
    .wb_clk_i(clk), .wb_rst_i(rst[1]), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]),
    .wbs_we_i(we[1]), .wbs_sel_i(sel[1]), .wbs_adr_i(adr[1]), .wbs_dat_i(dat[1]),
    .wbs_ack_o(ack[1]), .wbs_dat_o(dat_o[1]), .hw_we_i(hw_we[1]), .hw_dat_i(hw_dat[1]),
    .regs_o(regs[1]), .wr_pulse_o(pulse[1]));

  // Model state and per-cycle expectations
  logic [31:0] m [2][8];
  logic        exp_ack [2], exp_wr [2];
  logic [31:0] exp_dat [2];
  logic [7:0]  exp_pulse [2];
  logic        chk_en = 1'b0;
  int          tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] pk(input int d);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = m[d][k];
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("ack%0d", d), 256'(ack[d]), 256'(exp_ack[d]));
        if (!(exp_ack[d] && exp_wr[d]))
          chk($sformatf("dat_o%0d", d), 256'(dat_o[d]), 256'(exp_dat[d]));
        chk($sformatf("pulse%0d", d), 256'(pulse[d]), 256'(exp_pulse[d]));
        chk($sformatf("regs%0d", d), regs[d], pk(d));
      end
    end
  end

  // One bus transaction; optional hardware load driven alongside the request.
  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input logic [7:0] hwm, input logic [31:0] hwv,
                      output logic [31:0] rd);
    int  ws;
    bit  hit;
    int  idx;
    ws = (d == 0) ? 0 : 3;
    @(posedge clk); #1;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dat[d] = wd; sel[d] = s;
    hw_we[d] = hwm; hw_dat[d] = {8{hwv}};
    for (int k = 1; k <= ws + 1; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        for (int r = 0; r < 8; r++) if (hwm[r]) m[d][r] = hwv;
        hw_we[d] = 8'h0;
        adr[d] = ~a; dat[d] = ~wd; sel[d] = ~s;
      end
    end
    hit = (a >= B) && (a < B + 32);
    idx = int'((a - B) >> 2);
    exp_ack[d] = 1'b1;
    exp_wr[d]  = w;
    exp_dat[d] = w ? 32'h0 : (hit ? m[d][idx] : OOR);
    exp_pulse[d] = (w && hit) ? (8'h1 << idx) : 8'h0;
    if (w && hit)
      for (int n = 0; n < 4; n++) if (s[n]) m[d][idx][8*n +: 8] = wd[8*n +: 8];
    rd = dat_o[d];
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(posedge clk); #1;
    exp_ack[d] = 1'b0; exp_wr[d] = 1'b0; exp_dat[d] = 32'h0; exp_pulse[d] = 8'h0;
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
    logic [31:0] x;
    xfer(d, 1'b1, a, wd, s, 8'h0, 32'h0, x);
  endtask

  task automatic rd_chk(input int d, input logic [31:0] a, input logic [31:0] lit, input string nm);
    logic [31:0] x;
    xfer(d, 1'b0, a, 32'h0, 4'hF, 8'h0, 32'h0, x);
    chk(nm, 256'(x), 256'(lit));
  endtask

  initial begin
    logic [31:0] x;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; sel[d] = 4'h0;
      adr[d] = 32'h0; dat[d] = 32'h0; hw_we[d] = 8'h0; hw_dat[d] = '0;
      exp_ack[d] = 1'b0; exp_wr[d] = 1'b0; exp_dat[d] = 32'h0; exp_pulse[d] = 8'h0;
      for (int k = 0; k < 8; k++) m[d][k] = 32'h0;
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Basic writes and readback, zero wait states
    wr(0, B + 32'h0, 32'h0000_000C, 4'hF);
    wr(0, B + 32'h4, 32'h0000_0008, 4'hF);
    wr(0, B + 32'h8, 32'h0000_0007, 4'hF);
    rd_chk(0, B + 32'h0, 32'hC, "rd_reg0");
    rd_chk(0, B + 32'h4, 32'h8, "rd_reg1");
    rd_chk(0, B + 32'h8, 32'h7, "rd_reg2");
    rd_chk(0, B + 32'h5, 32'h8, "rd_lowbits_ignored");

    // Byte lanes
    wr(0, B, 32'hAABB_CCDD, 4'hF);
    wr(0, B, 32'h1111_1111, 4'b0000);
    chk("sel0000", 256'(regs[0][31:0]), 256'(32'hAABB_CCDD));
    wr(0, B, 32'h1111_1111, 4'b0101);
    chk("sel0101", 256'(regs[0][31:0]), 256'(32'hAA11_CC11));
    wr(0, B, 32'h1111_1111, 4'b1000);
    chk("sel1000", 256'(regs[0][31:0]), 256'(32'h1111_CC11));

    // Last register boundary and out-of-range both sides
    wr(0, B + 32'd28, 32'hDEAD_BEEF, 4'hF);
    rd_chk(0, B + 32'd28, 32'hDEAD_BEEF, "rd_last");
    rd_chk(0, B + 32'd32, OOR, "rd_oor_hi");
    rd_chk(0, B - 32'd4, OOR, "rd_oor_lo");
    wr(0, B + 32'd32, 32'hFFFF_FFFF, 4'hF);

    // Same-edge hardware and bus write to reg 1
    xfer(0, 1'b1, B + 32'h4, 32'hFFFF_FFFF, 4'b0011, 8'b0000_0010, 32'h1234_5678, x);
    chk("hw_vs_bus", 256'(regs[0][63:32]), 256'(32'h1234_FFFF));

    // Hardware-only update
    @(posedge clk); #1;
    hw_we[0] = 8'h20; hw_dat[0] = {8{32'h5A5A_5A5A}};
    @(posedge clk); #1;
    hw_we[0] = 8'h0; m[0][5] = 32'h5A5A_5A5A;
    chk("hw_only", 256'(regs[0][191:160]), 256'(32'h5A5A_5A5A));

    // Three wait states: latency is checked cycle by cycle
    wr(1, B + 32'h8, 32'hCAFE_F00D, 4'hF);
    rd_chk(1, B + 32'h8, 32'hCAFE_F00D, "ws3_rd");

    // Abort in WAIT: strobe dropped after two cycles
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = B + 32'h8; dat[1] = 32'h0; sel[1] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_keep", 256'(regs[1][95:64]), 256'(32'hCAFE_F00D));
    rd_chk(1, B + 32'h8, 32'hCAFE_F00D, "after_abort");

    // Reset while a write is waiting
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = B; dat[1] = 32'h55; sel[1] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[1] = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) m[1][k] = 32'h0;
    rst[1] = 1'b0;
    chk("rst_regs", regs[1], 256'h0);
    repeat (5) @(posedge clk);
    #1;
    wr(1, B + 32'hC, 32'h0000_1234, 4'hF);
    rd_chk(1, B + 32'hC, 32'h0000_1234, "post_rst_rd");
    rd_chk(1, B + 32'h8, 32'h0, "post_rst_cleared");

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
